// File: rtl/rf_wb_arbiter_if.sv
// Register-file writeback bundle between two writeback sources (A: ALU,
// B: load), the register-file write port and the decode-stage hazard probe.
//
// Ports / signals:
//   a_valid/a_addr/a_data  -> ALU writeback request       (master drives)
//   a_ready                <- ALU request accepted        (slave drives)
//   b_valid/b_addr/b_data  -> load writeback request      (master drives)
//   b_ready                <- load request accepted       (slave drives)
//   WrX/waddr/DataIn       <- register-file write port    (slave drives)
//   chk_addr_1/chk_addr_2  -> decode source registers     (master drives)
//   hazard_1/hazard_2      <- pending-write flags         (slave drives)
//   conflict_cnt           <- saturating both-full count  (slave drives)
interface rf_wb_arbiter_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
);

  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_ready;

  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;

  logic          WrX;
  logic [AW-1:0] waddr;
  logic [DW-1:0] DataIn;

  logic [AW-1:0] chk_addr_1;
  logic [AW-1:0] chk_addr_2;
  logic          hazard_1;
  logic          hazard_2;

  logic [7:0]    conflict_cnt;

  // Requester / pipeline side.
  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output chk_addr_1, chk_addr_2,
    input  a_ready, b_ready,
    input  WrX, waddr, DataIn,
    input  hazard_1, hazard_2,
    input  conflict_cnt
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  chk_addr_1, chk_addr_2,
    output a_ready, b_ready,
    output WrX, waddr, DataIn,
    output hazard_1, hazard_2,
    output conflict_cnt
  );

endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-source register-file writeback arbiter.
//
// Each requester (A = ALU, B = load) owns a one-entry slot. Every cycle at
// most one full slot is granted; the grant is written to the register file
// on the following edge through registered WrX/waddr/DataIn. Arbitration is
// round-robin, except that two pending writes to the same register retire
// in arrival order so the newer value lands last.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - rf_wb_arbiter_if.slave: request handshakes, register-file write
//          port, hazard probe and contention counter
module rf_wb_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int unsigned   CW      = 8;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  typedef struct packed {
    logic          full;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } slot_t;

  // Registered state
  slot_t         slot_a_q, slot_a_d;
  slot_t         slot_b_q, slot_b_d;
  logic          older_b_q, older_b_d;   // 1: B holds the older write
  ptr_e          ptr_q, ptr_d;
  logic          wrx_q, wrx_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Combinational control
  logic both_full;
  logic same_addr;
  logic gnt_a;
  logic gnt_b;
  logic a_ready;
  logic b_ready;
  logic acc_a;
  logic acc_b;

  // True when a write to chk has not yet become visible in the register file.
  function automatic logic addr_pending(
    input logic [AW-1:0] chk,
    input slot_t         sa,
    input slot_t         sb,
    input logic          wrx,
    input logic [AW-1:0] wa
  );
    addr_pending = (sa.full && (sa.addr == chk)) ||
                   (sb.full && (sb.addr == chk)) ||
                   (wrx     && (wa      == chk));
  endfunction

  assign both_full = slot_a_q.full & slot_b_q.full;
  assign same_addr = (slot_a_q.addr == slot_b_q.addr);

  // Grant selection: a lone full slot always wins; with both full, the
  // older write wins on an address match, otherwise the pointer decides.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (both_full) begin
      if (same_addr) begin
        gnt_a = ~older_b_q;
        gnt_b = older_b_q;
      end else begin
        gnt_a = (ptr_q == PTR_A);
        gnt_b = (ptr_q == PTR_B);
      end
    end else begin
      gnt_a = slot_a_q.full;
      gnt_b = slot_b_q.full;
    end
  end

  // Ready depends only on slot state, so a slot draining this cycle can
  // refill on the same edge and a single source sustains one write per cycle.
  assign a_ready = ~slot_a_q.full | gnt_a;
  assign b_ready = ~slot_b_q.full | gnt_b;
  assign acc_a   = bus.a_valid & a_ready;
  assign acc_b   = bus.b_valid & b_ready;

  // Next-state logic for slots, age, pointer, write port and counter.
  always_comb begin
    slot_a_d  = slot_a_q;
    slot_b_d  = slot_b_q;
    older_b_d = older_b_q;
    ptr_d     = ptr_q;
    wrx_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;

    // Drain the granted slot; a same-edge accept overrides the clear.
    if (gnt_a) begin
      slot_a_d.full = 1'b0;
    end
    if (gnt_b) begin
      slot_b_d.full = 1'b0;
    end
    if (acc_a) begin
      slot_a_d = '{full: 1'b1, addr: bus.a_addr, data: bus.a_data};
    end
    if (acc_b) begin
      slot_b_d = '{full: 1'b1, addr: bus.b_addr, data: bus.b_data};
    end

    // Age: the slot loaded later is newer; a simultaneous load makes A older.
    // When the other slot ends up empty the bit is simply don't-care.
    if (acc_a && acc_b) begin
      older_b_d = 1'b0;
    end else if (acc_a) begin
      older_b_d = 1'b1;
    end else if (acc_b) begin
      older_b_d = 1'b0;
    end

    // Register-file write one edge after the grant.
    if (gnt_a) begin
      wrx_d   = 1'b1;
      waddr_d = slot_a_q.addr;
      wdata_d = slot_a_q.data;
      ptr_d   = PTR_B;
    end else if (gnt_b) begin
      wrx_d   = 1'b1;
      waddr_d = slot_b_q.addr;
      wdata_d = slot_b_q.data;
      ptr_d   = PTR_A;
    end

    // Count edges that see both slots occupied before the grant.
    if (both_full && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_a_q  <= '0;
      slot_b_q  <= '0;
      older_b_q <= 1'b0;
      ptr_q     <= PTR_A;
      wrx_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      slot_a_q  <= slot_a_d;
      slot_b_q  <= slot_b_d;
      older_b_q <= older_b_d;
      ptr_q     <= ptr_d;
      wrx_q     <= wrx_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.a_ready      = a_ready;
  assign bus.b_ready      = b_ready;
  assign bus.WrX          = wrx_q;
  assign bus.waddr        = waddr_q;
  assign bus.DataIn       = wdata_q;
  assign bus.conflict_cnt = cnt_q;

  // Decode-stage hazard probes.
  assign bus.hazard_1 = addr_pending(bus.chk_addr_1, slot_a_q, slot_b_q, wrx_q, waddr_q);
  assign bus.hazard_2 = addr_pending(bus.chk_addr_2, slot_a_q, slot_b_q, wrx_q, waddr_q);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   pulses;

  rf_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.a_valid = v;
    bus.a_addr  = a;
    bus.a_data  = d;
  endtask

  task automatic drive_b(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.b_valid = v;
    bus.b_addr  = a;
    bus.b_data  = d;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    pulses = 0;
    rst    = 1'b0;
    drive_a(1'b1, 4'd1, 16'h0001);
    drive_b(1'b0, 4'd0, 16'h0000);
    bus.chk_addr_1 = 4'd1;
    bus.chk_addr_2 = 4'd0;

    // Reset values; a request during reset must not be taken.
    #3;
    check("rst_wrx",   32'(bus.WrX),          32'd0);
    check("rst_waddr", 32'(bus.waddr),        32'd0);
    check("rst_data",  32'(bus.DataIn),       32'd0);
    check("rst_cnt",   32'(bus.conflict_cnt), 32'd0);
    check("rst_ardy",  32'(bus.a_ready),      32'd1);
    check("rst_brdy",  32'(bus.b_ready),      32'd1);
    step();
    check("rst_noacc_haz", 32'(bus.hazard_1), 32'd0);
    drive_a(1'b0, 4'd0, 16'h0000);
    #2 rst = 1'b1;
    step();
    check("rel_wrx", 32'(bus.WrX), 32'd0);

    // Single write: slot loads, written next edge, then idle.
    drive_a(1'b1, 4'd3, 16'h1234);
    step();
    drive_a(1'b0, 4'd0, 16'h0000);
    check("single_load_wrx", 32'(bus.WrX), 32'd0);
    step();
    check("single_wrx",   32'(bus.WrX),    32'd1);
    check("single_waddr", 32'(bus.waddr),  32'd3);
    check("single_data",  32'(bus.DataIn), 32'h1234);
    step();
    check("single_idle_wrx",  32'(bus.WrX),    32'd0);
    check("single_hold_addr", 32'(bus.waddr),  32'd3);
    check("single_hold_data", 32'(bus.DataIn), 32'h1234);

    // Hazard tracking through slot and write cycle.
    bus.chk_addr_1 = 4'd9;
    bus.chk_addr_2 = 4'd3;
    drive_a(1'b1, 4'd9, 16'h5A5A);
    #1;
    check("haz_before", 32'(bus.hazard_1), 32'd0);
    check("haz2_stale", 32'(bus.hazard_2), 32'd0);
    step();
    drive_a(1'b0, 4'd0, 16'h0000);
    #1;
    check("haz_slot",  32'(bus.hazard_1), 32'd1);
    check("haz2_slot", 32'(bus.hazard_2), 32'd0);
    step();
    check("haz_wrx_cycle", 32'(bus.hazard_1), 32'd1);
    check("haz_wrx",       32'(bus.WrX),      32'd1);
    step();
    check("haz_after", 32'(bus.hazard_1), 32'd0);

    // Contention right after reset: A first, then B; one conflict edge.
    rst = 1'b0;
    #2;
    check("rst2_cnt", 32'(bus.conflict_cnt), 32'd0);
    rst = 1'b1;
    step();
    drive_a(1'b1, 4'd2, 16'h1111);
    drive_b(1'b1, 4'd5, 16'h2222);
    step();
    drive_a(1'b0, 4'd0, 16'h0000);
    drive_b(1'b0, 4'd0, 16'h0000);
    #1;
    check("cont_load_wrx", 32'(bus.WrX),     32'd0);
    check("cont_ardy",     32'(bus.a_ready), 32'd1);
    check("cont_brdy",     32'(bus.b_ready), 32'd0);
    step();
    check("cont1_wrx",   32'(bus.WrX),          32'd1);
    check("cont1_waddr", 32'(bus.waddr),        32'd2);
    check("cont1_data",  32'(bus.DataIn),       32'h1111);
    check("cont1_cnt",   32'(bus.conflict_cnt), 32'd1);
    step();
    check("cont2_wrx",   32'(bus.WrX),          32'd1);
    check("cont2_waddr", 32'(bus.waddr),        32'd5);
    check("cont2_data",  32'(bus.DataIn),       32'h2222);
    check("cont2_cnt",   32'(bus.conflict_cnt), 32'd1);
    step();
    check("cont_idle_wrx", 32'(bus.WrX), 32'd0);

    // Same address with pointer on B: older A must still retire first.
    drive_a(1'b1, 4'd1, 16'h0101);
    step();
    drive_a(1'b1, 4'd7, 16'hAAAA);
    drive_b(1'b1, 4'd7, 16'hBBBB);
    step();
    drive_a(1'b0, 4'd0, 16'h0000);
    drive_b(1'b0, 4'd0, 16'h0000);
    #1;
    check("same_pre_waddr", 32'(bus.waddr),   32'd1);
    check("same_ardy",      32'(bus.a_ready), 32'd1);
    check("same_brdy",      32'(bus.b_ready), 32'd0);
    step();
    check("same1_waddr", 32'(bus.waddr),          32'd7);
    check("same1_data",  32'(bus.DataIn),         32'hAAAA);
    check("same1_cnt",   32'(bus.conflict_cnt),   32'd2);
    step();
    check("same2_wrx",   32'(bus.WrX),    32'd1);
    check("same2_data",  32'(bus.DataIn), 32'hBBBB);
    step();
    check("same_end_wrx",  32'(bus.WrX),    32'd0);
    check("same_end_data", 32'(bus.DataIn), 32'hBBBB);

    // Back-to-back single requester: one write per cycle.
    for (int i = 0; i < 10; i++) begin
      drive_a(1'b1, AW'(i), DW'(32'h0100 + 32'(i)));
      #1;
      check("b2b_ardy", 32'(bus.a_ready), 32'd1);
      step();
      if (bus.WrX === 1'b1) pulses++;
      check("b2b_wrx", 32'(bus.WrX), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check("b2b_waddr", 32'(bus.waddr), 32'(i - 1));
    end
    drive_a(1'b0, 4'd0, 16'h0000);
    step();
    if (bus.WrX === 1'b1) pulses++;
    check("b2b_last_waddr", 32'(bus.waddr),  32'd9);
    check("b2b_last_data",  32'(bus.DataIn), 32'h0109);
    step();
    check("b2b_idle_wrx", 32'(bus.WrX), 32'd0);
    check("b2b_pulses",   32'(pulses),  32'd10);

    // Reset mid-operation with both slots full and a write in flight.
    bus.chk_addr_1 = 4'd4;
    drive_a(1'b1, 4'd4, 16'h4444);
    drive_b(1'b1, 4'd6, 16'h6666);
    step();
    drive_a(1'b0, 4'd0, 16'h0000);
    drive_b(1'b1, 4'd8, 16'h8888);
    step();
    drive_b(1'b0, 4'd0, 16'h0000);
    check("mid_wrx",   32'(bus.WrX),          32'd1);
    check("mid_waddr", 32'(bus.waddr),        32'd6);
    check("mid_cnt",   32'(bus.conflict_cnt), 32'd3);
    check("mid_haz",   32'(bus.hazard_1),     32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_wrx",   32'(bus.WrX),          32'd0);
    check("mid_rst_cnt",   32'(bus.conflict_cnt), 32'd0);
    check("mid_rst_waddr", 32'(bus.waddr),        32'd0);
    check("mid_rst_haz",   32'(bus.hazard_1),     32'd0);
    step();
    rst = 1'b1;
    step();
    check("post_rel1_wrx", 32'(bus.WrX), 32'd0);
    step();
    check("post_rel2_wrx", 32'(bus.WrX), 32'd0);

    // Continuous contention: counter saturates at 255.
    drive_a(1'b1, 4'd1, 16'hA001);
    drive_b(1'b1, 4'd2, 16'hB002);
    step();
    check("sat_start", 32'(bus.conflict_cnt), 32'd0);
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 254) check("sat_254", 32'(bus.conflict_cnt), 32'd254);
      if (k == 255) check("sat_255", 32'(bus.conflict_cnt), 32'd255);
      if (k == 300) check("sat_wrx", 32'(bus.WrX), 32'd1);
    end
    check("sat_final", 32'(bus.conflict_cnt), 32'd255);
    drive_a(1'b0, 4'd0, 16'h0000);
    drive_b(1'b0, 4'd0, 16'h0000);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DW, 16, data width of the register file write port.
REQ-002 Parameter AW, 4, register address width (16 registers).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 a_valid  in  1  ALU writeback request.
REQ-006 a_addr  in  AW  ALU destination register.
REQ-007 a_data  in  DW  ALU result.
REQ-008 a_ready  out  1  ALU request accepted this cycle when a_valid=1.
REQ-009 b_valid  in  1  memory/load writeback request.
REQ-010 b_addr  in  AW  load destination register.
REQ-011 b_data  in  DW  load data.
REQ-012 b_ready  out  1  load request accepted this cycle when b_valid=1.
REQ-013 WrX  out  1  register file write enable; registered.
REQ-014 waddr  out  AW  register file write address; registered.
REQ-015 DataIn  out  DW  register file write data; registered.
REQ-016 chk_addr_1  in  AW  decode-stage source register 1.
REQ-017 chk_addr_2  in  AW  decode-stage source register 2.
REQ-018 hazard_1  out  1  write to chk_addr_1 still pending; combinational.
REQ-019 hazard_2  out  1  write to chk_addr_2 still pending; combinational.
REQ-020 conflict_cnt  out  8  saturating count of cycles in which both slots were full.

Function
REQ-021 The block SHALL hold one slot per requester (A, B); each slot stores full flag, addr, data.
REQ-022 A request SHALL be accepted when valid=1 and ready=1; the slot loads on that edge.
REQ-023 Ready SHALL equal !full | granted-this-cycle; ready SHALL NOT depend combinationally on the same requester's valid.
REQ-024 Each cycle, at most one full slot SHALL be granted; the granted slot clears unless reloaded on the same edge.
REQ-025 Arbitration SHALL be round-robin: 1-bit pointer, reset value A; when both slots are full, the pointer's slot wins; after any grant, the pointer moves to the other slot.
REQ-026 Exception: when both slots are full with equal addr, the older slot (age bit) SHALL win regardless of pointer.
REQ-027 Age: a slot loaded while the other is full is newer; if both load on the same edge, A is older.
REQ-028 A grant SHALL produce WrX=1, waddr=slot addr, DataIn=slot data on the next edge: accept-to-WrX latency is 1 cycle with no contention.
REQ-029 With no grant, WrX SHALL be 0 next cycle; waddr/DataIn SHALL hold their previous values.
REQ-030 Sustained throughput SHALL be one write per cycle; a single requester valid every cycle SHALL be accepted every cycle.
REQ-031 hazard_n SHALL be 1 iff chk_addr_n equals the addr of any full slot, or WrX=1 and waddr=chk_addr_n.
REQ-032 conflict_cnt SHALL increment on each edge where both slots are full before grant, and saturate at 255.
REQ-033 Incoming requests SHALL NOT be forwarded combinationally to WrX/waddr/DataIn.

Reset
REQ-034 On rst=0, asynchronously: both slots empty, age cleared, pointer=A, WrX=0, waddr=0, DataIn=0, conflict_cnt=0.
REQ-035 Reset mid-operation SHALL discard buffered writes; no WrX pulse SHALL follow reset release without a new accept.
REQ-036 During reset a_ready=b_ready=1 is permitted, but no accept SHALL take effect until the first edge after rst=1.

Verification
REQ-037 Single write: A addr=3 data=0x1234 for one cycle -> next cycle WrX=1 waddr=3 DataIn=0x1234; following cycle WrX=0.
REQ-038 Contention: A(2,0x1111) and B(5,0x2222) same cycle after reset -> A written first, B second; conflict_cnt=1.
REQ-039 Same address: A(7,0xAAAA) held full, then B(7,0xBBBB) loads while pointer=B -> A written before B; r7 ends 0xBBBB.
REQ-040 Hazard: A(9,x) accepted, chk_addr_1=9 -> hazard_1=1 while the slot is full and in the WrX cycle, 0 the cycle after.
REQ-041 Back-to-back: A valid 10 cycles, B idle -> 10 consecutive WrX pulses; a_ready=1 throughout.
REQ-042 Reset: both slots full, rst=0 -> WrX=0, conflict_cnt=0 immediately; no write after release; 300 contended cycles -> conflict_cnt=255.
